// File: rtl/fifo_reader_3d.sv
// Reads 8-channel pixel words from an upstream FIFO, tags them with frame/row position,
// and streams NUM_IMG frames through a 2-entry output buffer; trailing pad frames are dropped.
module fifo_reader_3d #(
    parameter int DWIDTH      = 32,
    parameter int WIDTH       = 56,
    parameter int HEIGHT      = 56,
    parameter int NUM_IMG     = 1,
    parameter int NUM_PAD_IMG = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data_0,
    input  logic [DWIDTH-1:0] fifo_data_1,
    input  logic [DWIDTH-1:0] fifo_data_2,
    input  logic [DWIDTH-1:0] fifo_data_3,
    input  logic [DWIDTH-1:0] fifo_data_4,
    input  logic [DWIDTH-1:0] fifo_data_5,
    input  logic [DWIDTH-1:0] fifo_data_6,
    input  logic [DWIDTH-1:0] fifo_data_7,
    output logic              fifo_rdreq,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data_0,
    output logic [DWIDTH-1:0] out_data_1,
    output logic [DWIDTH-1:0] out_data_2,
    output logic [DWIDTH-1:0] out_data_3,
    output logic [DWIDTH-1:0] out_data_4,
    output logic [DWIDTH-1:0] out_data_5,
    output logic [DWIDTH-1:0] out_data_6,
    output logic [DWIDTH-1:0] out_data_7,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic [9:0]        frame_idx,
    output logic              done,
    output logic              error
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [9:0]    IMG_LAST = 10'(NUM_IMG - 1);
    localparam logic [9:0]    ALL_LAST = 10'(NUM_IMG + NUM_PAD_IMG - 1);

    typedef enum logic [1:0] {RUN, DISCARD, DONE} state_t;

    typedef struct packed {
        logic [7:0][DWIDTH-1:0] data;
        logic                   sof;
        logic                   eol;
        logic                   eof;
        logic [9:0]             fidx;
    } entry_t;

    state_t                 state;
    state_t                 state_next;
    logic                   inflight;
    logic [1:0]             occupancy;
    logic [2:0]             credit;
    entry_t                 head_entry;
    entry_t                 tail_entry;
    entry_t                 in_entry;
    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [9:0]             frame;
    logic [7:0][DWIDTH-1:0] in_data;
    logic                   last_col;
    logic                   last_row;
    logic                   word_eof;
    logic                   push;
    logic                   pop;

    assign in_data  = {fifo_data_7, fifo_data_6, fifo_data_5, fifo_data_4,
                       fifo_data_3, fifo_data_2, fifo_data_1, fifo_data_0};
    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);
    assign word_eof = last_col && last_row;

    always_comb begin
        in_entry      = '0;
        in_entry.data = in_data;
        in_entry.sof  = (col == '0) && (row == '0);
        in_entry.eol  = last_col;
        in_entry.eof  = word_eof;
        in_entry.fidx = frame;
    end

    // Routing follows the captured word's own frame count, so a word in flight across a state change lands correctly.
    assign push   = inflight && (frame <= IMG_LAST);
    assign pop    = out_valid && out_ready;
    assign credit = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (inflight && word_eof) begin
            if (frame == ALL_LAST)      state_next = DONE;
            else if (frame == IMG_LAST) state_next = DISCARD;
        end
    end

    // Looking at state_next stops a request in the cycle the final word is captured, so no word past the last frame is popped.
    always_comb begin
        fifo_rdreq = 1'b0;
        if (!reset && !fifo_empty && state_next != DONE)
            fifo_rdreq = (state == DISCARD) || (credit < 3'd2);
        done = (state == DONE) && (occupancy == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
            error    <= 1'b0;
        end else begin
            inflight <= fifo_rdreq;
            if (fifo_rdreq && fifo_empty) error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col   <= '0;
            row   <= '0;
            frame <= '0;
        end else if (inflight) begin
            if (last_col) begin
                col <= '0;
                if (last_row) begin
                    row   <= '0;
                    frame <= frame + 10'd1;
                end else begin
                    row <= row + RW'(1);
                end
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Head entry drives the outputs; it only moves on a pop, which keeps the word stable while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy  <= 2'd0;
            head_entry <= '0;
            tail_entry <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occupancy == 2'd0) head_entry <= in_entry;
                    else                   tail_entry <= in_entry;
                    occupancy <= occupancy + 2'd1;
                end
                2'b01: begin
                    head_entry <= tail_entry;
                    occupancy  <= occupancy - 2'd1;
                end
                2'b11: begin
                    if (occupancy == 2'd1) begin
                        head_entry <= in_entry;
                    end else begin
                        head_entry <= tail_entry;
                        tail_entry <= in_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid  = (occupancy != 2'd0);
    assign out_data_0 = head_entry.data[0];
    assign out_data_1 = head_entry.data[1];
    assign out_data_2 = head_entry.data[2];
    assign out_data_3 = head_entry.data[3];
    assign out_data_4 = head_entry.data[4];
    assign out_data_5 = head_entry.data[5];
    assign out_data_6 = head_entry.data[6];
    assign out_data_7 = head_entry.data[7];
    assign out_sof    = head_entry.sof;
    assign out_eol    = head_entry.eol;
    assign out_eof    = head_entry.eof;
    assign frame_idx  = head_entry.fidx;

endmodule

// File: tb/tb_fifo_reader_3d.sv
// Self-checking bench: two readers (one pad frame / no pad frames) share stimulus; each keeps
// a positional scoreboard of words read from its own FIFO model.
module tb_fifo_reader_3d;

    localparam int DW    = 32;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int FRAME = W * H;
    localparam int NIMG  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fifo_empty = 1'b1;
    logic out_ready = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct packed {
        logic [31:0] val;
        logic        sof;
        logic        eol;
        logic        eof;
        logic [9:0]  fidx;
    } rec_t;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int PAD   = (g == 0) ? 1 : 0;
        localparam int TOTAL = (NIMG + PAD) * FRAME;
        localparam int DELIV = NIMG * FRAME;

        logic [DW-1:0] fd [8];
        logic [DW-1:0] od [8];
        logic          rdreq, out_valid, sof, eol, eof, done, error;
        logic [9:0]    fidx;

        fifo_reader_3d #(
            .DWIDTH(DW), .WIDTH(W), .HEIGHT(H), .NUM_IMG(NIMG), .NUM_PAD_IMG(PAD)
        ) dut (
            .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
            .fifo_data_0(fd[0]), .fifo_data_1(fd[1]), .fifo_data_2(fd[2]), .fifo_data_3(fd[3]),
            .fifo_data_4(fd[4]), .fifo_data_5(fd[5]), .fifo_data_6(fd[6]), .fifo_data_7(fd[7]),
            .fifo_rdreq(rdreq), .out_ready(out_ready), .out_valid(out_valid),
            .out_data_0(od[0]), .out_data_1(od[1]), .out_data_2(od[2]), .out_data_3(od[3]),
            .out_data_4(od[4]), .out_data_5(od[5]), .out_data_6(od[6]), .out_data_7(od[7]),
            .out_sof(sof), .out_eol(eol), .out_eof(eof), .frame_idx(fidx),
            .done(done), .error(error)
        );

        rec_t          q[$];
        rec_t          e;
        rec_t          held_rec;
        logic [DW-1:0] held [8];
        logic [31:0]   pend_val = '0;
        int            k = 0;
        int            fifo_next = 1;
        int            n_out = 0;
        int            first_out = -1;
        int            last_out = -1;
        bit            infl = 0, pend = 0, stall_prev = 0, prev_reset = 0;

        // Upstream FIFO: data for a request appears one cycle later, garbage otherwise.
        initial forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 8; c++)
                fd[c] = pend ? {4'(c), pend_val[27:0]} : $urandom;
            pend = 0;
        end

        always @(negedge clk) begin
            if (reset) begin
                checkOutput($sformatf("L%0d rdreq_in_reset", g), rdreq, 1'b0);
                q.delete();
                k = 0;
                infl = 0;
                stall_prev = 0;
                prev_reset = 1;
            end else begin
                if (prev_reset) begin
                    checkOutput($sformatf("L%0d valid_after_reset", g), out_valid, 1'b0);
                    prev_reset = 0;
                end
                checkOutput($sformatf("L%0d done", g), done, (k == TOTAL && !infl && q.size() == 0));
                checkOutput($sformatf("L%0d error", g), error, 1'b0);
                checkOutput($sformatf("L%0d rdreq_while_empty", g), rdreq && fifo_empty, 1'b0);
                checkOutput($sformatf("L%0d buffer_bound", g), q.size() <= 2, 1'b1);
                if (!out_ready && q.size() >= 2 && k < DELIV)
                    checkOutput($sformatf("L%0d rdreq_when_full", g), rdreq, 1'b0);
                if (stall_prev) begin
                    checkOutput($sformatf("L%0d stall_valid", g), out_valid, 1'b1);
                    checkOutput($sformatf("L%0d stall_tags", g), {sof, eol, eof, fidx},
                                {held_rec.sof, held_rec.eol, held_rec.eof, held_rec.fidx});
                    for (int c = 0; c < 8; c++)
                        checkOutput($sformatf("L%0d stall_data%0d", g, c), od[c], held[c]);
                end
                stall_prev = out_valid && !out_ready;
                held_rec = '{val: '0, sof: sof, eol: eol, eof: eof, fidx: fidx};
                for (int c = 0; c < 8; c++) held[c] = od[c];
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checkOutput($sformatf("L%0d unexpected_output", g), 1'b1, 1'b0);
                    end else begin
                        e = q.pop_front();
                        for (int c = 0; c < 8; c++)
                            checkOutput($sformatf("L%0d data%0d", g, c), od[c], {4'(c), e.val[27:0]});
                        checkOutput($sformatf("L%0d sof", g), sof, e.sof);
                        checkOutput($sformatf("L%0d eol", g), eol, e.eol);
                        checkOutput($sformatf("L%0d eof", g), eof, e.eof);
                        checkOutput($sformatf("L%0d frame_idx", g), fidx, e.fidx);
                    end
                    if (first_out < 0) first_out = cycle;
                    last_out = cycle;
                    n_out++;
                end
                infl = rdreq;
                if (rdreq) begin
                    checkOutput($sformatf("L%0d read_past_end", g), k < TOTAL, 1'b1);
                    // Position follows purely from how many words were read since reset.
                    e.val  = fifo_next;
                    e.sof  = (k % FRAME) == 0;
                    e.eol  = (k % W) == W - 1;
                    e.eof  = (k % FRAME) == FRAME - 1;
                    e.fidx = 10'(k / FRAME);
                    if (k < DELIV) q.push_back(e);
                    k++;
                    pend = 1;
                    pend_val = fifo_next;
                    fifo_next++;
                end
            end
        end
    end

    task automatic clearCounts();
        lane[0].n_out = 0; lane[0].first_out = -1; lane[0].last_out = -1;
        lane[1].n_out = 0; lane[1].first_out = -1; lane[1].last_out = -1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        clearCounts();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // emode/rmode: 0 = empty low / ready high, 1 = toggle / ready low, 2 = random.
    task automatic applyStimulus(input string tag, input int budget, input int emode,
                                 input int rmode, input bit until_done);
        bit finished = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            case (emode)
                0:       fifo_empty = 1'b0;
                1:       fifo_empty = ~fifo_empty;
                default: fifo_empty = 1'($urandom_range(0, 1));
            endcase
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (until_done && lane[0].done && lane[1].done) begin
                finished = 1;
                break;
            end
        end
        if (until_done) checkOutput({tag, " reached_done"}, finished, 1'b1);
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, " L0 outputs"}, lane[0].n_out, 16);
        checkOutput({tag, " L1 outputs"}, lane[1].n_out, 16);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput("reset out_valid", (g == 0) ? lane[0].out_valid : lane[1].out_valid, 1'b0);
            checkOutput("reset done", (g == 0) ? lane[0].done : lane[1].done, 1'b0);
        end
        checkOutput("reset out_data_0", lane[0].od[0], '0);
        checkOutput("reset out_data_7", lane[0].od[7], '0);
        checkOutput("reset tags", {lane[0].sof, lane[0].eol, lane[0].eof, lane[0].fidx}, '0);
        checkOutput("reset error", lane[0].error, 1'b0);

        $display("[TB] phase A: full-rate stream");
        @(posedge clk);
        #1;
        reset = 1'b0;
        fifo_empty = 1'b0;
        out_ready = 1'b1;
        clearCounts();
        @(negedge clk);
        checkOutput("latency rdreq_c0", lane[0].rdreq, 1'b1);
        checkOutput("latency valid_c0", lane[0].out_valid, 1'b0);
        @(negedge clk);
        checkOutput("latency valid_c1", lane[0].out_valid, 1'b0);
        @(negedge clk);
        checkOutput("latency valid_c2", lane[0].out_valid, 1'b1);
        applyStimulus("A", 100, 0, 0, 1);
        checkCounts("A");
        checkOutput("A throughput", lane[0].last_out - lane[0].first_out, 15);

        $display("[TB] phase B: 10-cycle downstream stall");
        doReset();
        applyStimulus("B1", 6, 0, 0, 0);
        applyStimulus("B2", 10, 0, 1, 0);
        checkOutput("B stalled rdreq", lane[0].rdreq, 1'b0);
        checkOutput("B stalled valid", lane[0].out_valid, 1'b1);
        applyStimulus("B3", 300, 0, 0, 1);
        checkCounts("B");

        $display("[TB] phase C: toggling fifo_empty");
        doReset();
        applyStimulus("C", 300, 1, 0, 1);
        checkCounts("C");

        $display("[TB] phase D: reset mid-frame");
        doReset();
        for (int i = 0; i < 50 && lane[0].k < 5; i++) applyStimulus("D1", 1, 0, 0, 0);
        checkOutput("D words before reset", lane[0].k, 5);
        doReset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lane[0].out_valid) break;
        end
        checkOutput("D first valid", lane[0].out_valid, 1'b1);
        checkOutput("D first sof", lane[0].sof, 1'b1);
        checkOutput("D first frame_idx", lane[0].fidx, 10'd0);
        applyStimulus("D2", 300, 0, 0, 1);
        checkCounts("D");

        $display("[TB] phase E: random empty/ready");
        doReset();
        applyStimulus("E", 3000, 2, 2, 1);
        checkCounts("E");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
